// File: rtl/dlx_bus_responder_if.sv
// DLX external memory bus: address strobe / write select / address / data out
// from the core, acknowledge / read data / sticky error back from the responder.
interface dlx_bus_responder_if;
  logic        as_N;
  logic        wr_N;
  logic [31:0] MAO;
  logic [31:0] MDO;
  logic        ACK_N;
  logic [31:0] DI;
  logic        bus_err;

  modport master (
    output as_N, wr_N, MAO, MDO,
    input  ACK_N, DI, bus_err
  );

  modport slave (
    input  as_N, wr_N, MAO, MDO,
    output ACK_N, DI, bus_err
  );
endinterface

// File: rtl/dlx_bus_responder.sv
// Word RAM bus responder for the DLX with programmable wait states.
// Optional RESP_STATS_EN adds saturating hit counters readable at STAT_ADDR.
module dlx_bus_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] STAT_ADDR   = 32'hFFFF_FFF0
) (
  input logic               CLK_IN,
  input logic               RST_N,
  dlx_bus_responder_if.slave bus
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] WIN_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << DEPTH_LOG2);
`ifdef RESP_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, ACK, REL} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        cap_write_reg;
  logic [31:0] cap_addr_reg;
  logic [31:0] cap_data_reg;
  logic        ack_n_reg;
  logic        bus_err_reg;
  logic [31:0] di_reg;
`ifdef RESP_STATS_EN
  logic [15:0] rd_cnt_reg;
  logic [15:0] wr_cnt_reg;
`endif

  logic [31:0]           ram [DEPTH];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  ram_hit;
  logic                  stat_sel;
  logic                  ack_go;

  // ADDR_BASE is aligned to the window size, so the low address bits are the word index
  assign word_idx = cap_addr_reg[DEPTH_LOG2+1:2];
  assign ram_hit  = ({1'b0, cap_addr_reg} >= WIN_LO) && ({1'b0, cap_addr_reg} < WIN_HI);
  assign stat_sel = STATS_ON && (cap_addr_reg[31:2] == STAT_ADDR[31:2]);
  // The capture edge is not a wait cycle: ACK_N falls WAIT_STATES+1 edges after capture
  assign ack_go   = (state_reg == WAIT) && !bus.as_N && (cnt_reg == 4'd0);

  always_ff @(posedge CLK_IN) begin
    if (ack_go && cap_write_reg && ram_hit && !stat_sel) begin
      ram[word_idx] <= cap_data_reg;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      cap_write_reg <= 1'b0;
      cap_addr_reg  <= 32'h0;
      cap_data_reg  <= 32'h0;
      ack_n_reg     <= 1'b1;
      bus_err_reg   <= 1'b0;
      di_reg        <= 32'h0;
`ifdef RESP_STATS_EN
      rd_cnt_reg    <= 16'h0;
      wr_cnt_reg    <= 16'h0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (!bus.as_N) begin
            cap_write_reg <= !bus.wr_N;
            cap_addr_reg  <= bus.MAO;
            cap_data_reg  <= bus.MDO;
            cnt_reg       <= 4'(WAIT_STATES);
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.as_N) begin
            state_reg <= IDLE;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ACK;
            ack_n_reg <= 1'b0;
            if (stat_sel) begin
`ifdef RESP_STATS_EN
              if (cap_write_reg) begin
                rd_cnt_reg <= 16'h0;
                wr_cnt_reg <= 16'h0;
              end else begin
                di_reg <= {rd_cnt_reg, wr_cnt_reg};
              end
`endif
            end else if (ram_hit) begin
              if (!cap_write_reg) begin
                di_reg <= ram[word_idx];
              end
`ifdef RESP_STATS_EN
              if (cap_write_reg && wr_cnt_reg != 16'hFFFF) wr_cnt_reg <= wr_cnt_reg + 16'd1;
              if (!cap_write_reg && rd_cnt_reg != 16'hFFFF) rd_cnt_reg <= rd_cnt_reg + 16'd1;
`endif
            end else begin
              di_reg      <= 32'h0;
              bus_err_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ACK: begin
          if (bus.as_N) begin
            state_reg <= REL;
            ack_n_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ACK_N   = ack_n_reg;
  assign bus.DI      = di_reg;
  assign bus.bus_err = bus_err_reg;

endmodule
